// File: rtl/xc_malu_div_seq_pkg.sv
// Shared malu divider definitions: FSM encodings, step count, op indices.
// Used by the sequencer and the step unit.
package xc_malu_div_seq_pkg;

    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = 6;

    localparam int OP_DIV  = 0;
    localparam int OP_DIVU = 1;
    localparam int OP_REM  = 2;
    localparam int OP_REMU = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic op_signed;
        logic want_rem;
    } div_op_t;

    // Priority div > divu > rem > remu.
    function automatic div_op_t decode_op(input logic [3:0] op);
        div_op_t d;
        d = '0;
        if (op[OP_DIV]) begin
            d.op_signed = 1'b1;
        end else if (op[OP_DIVU]) begin
            d.op_signed = 1'b0;
        end else if (op[OP_REM]) begin
            d.op_signed = 1'b1;
            d.want_rem  = 1'b1;
        end else if (op[OP_REMU]) begin
            d.want_rem  = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/xc_malu_div_seq_divrem.sv
// xc_malu_divrem: one restoring-division step on operand magnitudes.
// acc = |divisor|, arg_0 = partial remainder, arg_1 = dividend/quotient.
module xc_malu_divrem
    import xc_malu_div_seq_pkg::*;
(
    input  logic             flush,
    input  logic             valid,
    input  logic             start,
    input  logic             op_signed,
    input  logic [31:0]      rs1,
    input  logic [31:0]      rs2,
    input  logic [CNT_W-1:0] count,
    input  logic [31:0]      acc,
    input  logic [31:0]      arg_0,
    input  logic [31:0]      arg_1,
    output logic [31:0]      n_acc,
    output logic [31:0]      n_arg_0,
    output logic [31:0]      n_arg_1,
    output logic             ready
);

    logic [31:0] abs_1;
    logic [31:0] abs_2;
    logic [33:0] trial;
    logic        fits;
    logic        go;

    // Start values on the first cycle, one shift/subtract step after.
    always_comb begin
        go      = valid & ~flush;
        abs_1   = (op_signed & rs1[31]) ? (32'd0 - rs1) : rs1;
        abs_2   = (op_signed & rs2[31]) ? (32'd0 - rs2) : rs2;
        trial   = {1'b0, arg_0, arg_1[31]} - {2'b00, acc};
        fits    = ~trial[33];
        n_acc   = acc;
        n_arg_0 = arg_0;
        n_arg_1 = arg_1;
        if (go && start) begin
            n_acc   = abs_2;
            n_arg_0 = 32'd0;
            n_arg_1 = abs_1;
        end else if (go) begin
            n_arg_0 = fits ? trial[31:0] : {arg_0[30:0], arg_1[31]};
            n_arg_1 = {arg_1[30:0], fits};
        end
        ready = go & ~start & (count == CNT_W'(DIV_STEPS));
    end

endmodule

// File: rtl/xc_malu_div_seq.sv
// Divide sequencer: runs xc_malu_divrem for 32 steps, then sign-fixes.
// Optional XC_MALU_DIV_ZERO_FAST_EN: divide-by-zero completes in 1 cycle.
module xc_malu_div_seq
    import xc_malu_div_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            flush,
    input  logic            valid,
    input  logic            op_div,
    input  logic            op_divu,
    input  logic            op_rem,
    input  logic            op_remu,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            ready,
    output logic [XLEN-1:0] result
);

    div_state_t       state;
    div_state_t       state_n;
    div_op_t          dec;
    logic [CNT_W-1:0] count;
    logic [31:0]      acc;
    logic [31:0]      arg_0;
    logic [31:0]      arg_1;
    logic [31:0]      n_acc;
    logic [31:0]      n_arg_0;
    logic [31:0]      n_arg_1;
    logic             step_valid;
    logic             step_ready;
    logic             want_rem;
    logic             neg_q;
    logic             neg_r;
    logic             rs2_zero;
    logic             accept;
    logic             fast_zero;
    logic [31:0]      fin;

    assign dec      = decode_op({op_remu, op_rem, op_divu, op_div});
    assign rs2_zero = (rs2 == '0);
    assign accept   = (state == ST_IDLE) & valid;

`ifdef XC_MALU_DIV_ZERO_FAST_EN
    assign fast_zero = rs2_zero;
`else
    assign fast_zero = 1'b0;
`endif

    xc_malu_divrem u_divrem (
        .flush     (flush),
        .valid     (step_valid),
        .start     (state == ST_IDLE),
        .op_signed (dec.op_signed),
        .rs1       (rs1),
        .rs2       (rs2),
        .count     (count),
        .acc       (acc),
        .arg_0     (arg_0),
        .arg_1     (arg_1),
        .n_acc     (n_acc),
        .n_arg_0   (n_arg_0),
        .n_arg_1   (n_arg_1),
        .ready     (step_ready)
    );

    // Sign correction of the captured quotient/remainder.
    always_comb begin
        fin = want_rem ? (neg_r ? (32'd0 - arg_0) : arg_0)
                       : (neg_q ? (32'd0 - arg_1) : arg_1);
    end

    // State register; flush acts like reset.
    always_ff @(posedge clock) begin
        if (!resetn || flush) state <= ST_IDLE;
        else                  state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: if (valid) state_n = fast_zero ? ST_DONE : ST_RUN;
            ST_RUN:  if (step_ready) state_n = ST_DONE;
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs and step-unit enable decoded from state.
    always_comb begin
        busy       = (state == ST_RUN) | (state == ST_DONE);
        ready      = (state == ST_DONE);
        step_valid = (accept & ~fast_zero) | (state == ST_RUN);
    end

    // Datapath registers: operand load, step writeback, result capture.
    always_ff @(posedge clock) begin
        if (!resetn || flush) begin
            count    <= '0;
            acc      <= '0;
            arg_0    <= '0;
            arg_1    <= '0;
            want_rem <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result   <= '0;
        end else if (accept) begin
            count    <= '0;
            acc      <= n_acc;
            arg_0    <= n_arg_0;
            arg_1    <= n_arg_1;
            want_rem <= dec.want_rem;
            neg_q    <= dec.op_signed & (rs1[31] ^ rs2[31]) & ~rs2_zero;
            neg_r    <= dec.op_signed & rs1[31];
            if (fast_zero) result <= dec.want_rem ? rs1 : '1;
        end else if (state == ST_RUN) begin
            if (step_ready) begin
                result <= fin;
            end else begin
                acc   <= n_acc;
                arg_0 <= n_arg_0;
                arg_1 <= n_arg_1;
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xc_malu_div_seq.sv
// Scoreboard bench for xc_malu_div_seq with a RISC-V arithmetic reference.
// Honours XC_MALU_DIV_ZERO_FAST_EN for the expected divide-by-zero latency.
module tb_xc_malu_div_seq;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic        op_div = 1'b0;
    logic        op_divu = 1'b0;
    logic        op_rem = 1'b0;
    logic        op_remu = 1'b0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        busy;
    logic        ready;
    logic [31:0] result;

    xc_malu_div_seq dut (
        .clock   (clock),
        .resetn  (resetn),
        .flush   (flush),
        .valid   (valid),
        .op_div  (op_div),
        .op_divu (op_divu),
        .op_rem  (op_rem),
        .op_remu (op_remu),
        .rs1     (rs1),
        .rs2     (rs2),
        .busy    (busy),
        .ready   (ready),
        .result  (result)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          start;
        int          lat;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // RISC-V M-extension semantics, op: 0 div, 1 divu, 2 rem, 3 remu.
    function automatic logic [31:0] ref_model(input int op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sd;
        logic               ovf;
        sa  = a;
        sd  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            0: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'(sa / sd);
            end
            1: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return 32'(sa % sd);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Monitor: pops and compares whenever a result is presented.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (ready === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk({e.name, "_result"}, result, e.res);
                    chk({e.name, "_latency"}, 32'(cyc - e.start),
                        32'(e.lat));
                end
            end
        end
    end

    task automatic set_op(input int op);
        {op_remu, op_rem, op_divu, op_div} = 4'(1 << op);
    endtask

    // Wait for ready at negedges; a timeout counts as a failure.
    task automatic wait_ready(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clock);
            if (ready === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            chk({nm, "_timeout"}, 32'd0, 32'd1);
            sbq.delete();
            valid = 1'b0;
            flush = 1'b1;
            @(negedge clock);
            flush = 1'b0;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the next idle negedge.
    task automatic issue(input int op, input logic [31:0] a,
                         input logic [31:0] b, input string nm);
        exp_t e;
        e.res   = ref_model(op, a, b);
        e.start = cyc;
        e.name  = nm;
        e.lat   = 34;
`ifdef XC_MALU_DIV_ZERO_FAST_EN
        if (b == 0) e.lat = 1;
`endif
        set_op(op);
        rs1   = a;
        rs2   = b;
        valid = 1'b1;
        sbq.push_back(e);
        @(posedge clock);
        #1;
        rs1 = $urandom;
        rs2 = $urandom;
        {op_remu, op_rem, op_divu, op_div} = 4'($urandom);
        wait_ready(nm);
        valid = 1'b0;
        @(negedge clock);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(5, 0))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(20, 0));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_result", result, 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        issue(1, 32'd100, 32'd7, "divu_100_7");
        issue(3, 32'd100, 32'd7, "remu_100_7");
        issue(0, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        issue(2, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        issue(0, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        issue(2, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        issue(0, 32'hFFFF_FFF9, 32'd0, "div_by0");
        issue(2, 32'hFFFF_FFF9, 32'd0, "rem_by0");
        issue(1, 32'd1234, 32'd0, "divu_by0");
        issue(3, 32'd1234, 32'd0, "remu_by0");

        // Flush while RUN holds count 10.
        set_op(1);
        rs1   = 32'd55;
        rs2   = 32'd5;
        valid = 1'b1;
        @(posedge clock);
        #1;
        valid = 1'b0;
        repeat (11) @(negedge clock);
        chk("flush_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        chk("flush_busy_after", 32'(busy), 32'd0);
        chk("flush_result", result, 32'd0);
        repeat (40) @(negedge clock);
        chk("flush_no_ready", 32'(ready), 32'd0);
        issue(1, 32'd9, 32'd3, "divu_after_flush");

        issue(3, 32'hFFFF_FFFF, 32'h10, "remu_b2b");
        issue(0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, "div_negneg");
        issue(2, 32'd100, 32'hFFFF_FFF9, "rem_posneg");

        for (int i = 0; i < 40; i++) begin
            issue($urandom_range(3, 0), pick(), pick(),
                  $sformatf("rnd%0d", i));
        end

        repeat (5) @(negedge clock);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
